// File: rtl/iter_counter.sv
// iter_counter: mode-programmable iteration counter for CORDIC sequencing.
// A start/busy/done handshake runs a sequence of max_i steps, counting up
// or down, either once (one-shot) or repeatedly (wrap) until cleared.
// cnt_o indexes the iteration and the atan ROM of the micro-rotation datapath.

module iter_counter #(
    parameter int Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             start_i,
    input  logic             ena_i,
    input  logic             mode_i,
    input  logic             dir_i,
    input  logic [Width-1:0] max_i,
    output logic [Width-1:0] cnt_o,
    output logic             tick_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [Width-1:0] cnt_q, cnt_d;
    logic [Width-1:0] max_q, max_d;
    logic             mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;

    logic [Width-1:0] load_val;
    logic [Width-1:0] reload_val;
    logic [Width-1:0] term_val;
    logic             at_term;
    logic             start_ok;

    // Start value for a new run comes from the live inputs; the reload value
    // and terminal value for the running sequence come from the latched copy,
    // so max_i/dir_i may change freely while a run is in progress.
    always_comb begin
        load_val   = dir_i ? (max_i - Width'(1)) : '0;
        reload_val = dir_q ? (max_q - Width'(1)) : '0;
        term_val   = dir_q ? '0 : (max_q - Width'(1));
        at_term    = (cnt_q == term_val);
        start_ok   = (max_i != '0);
    end

    // Next-state logic: clear wins over everything, then the per-state rules.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        err_d   = 1'b0;

        if (clr_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (start_ok) begin
                            max_d   = max_i;
                            mode_d  = mode_i;
                            dir_d   = dir_i;
                            cnt_d   = load_val;
                            state_d = StRun;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (ena_i) begin
                        if (at_term) begin
                            if (mode_q) begin
                                state_d = StDone;
                            end else begin
                                cnt_d = reload_val;
                            end
                        end else if (dir_q) begin
                            cnt_d = cnt_q - Width'(1);
                        end else begin
                            cnt_d = cnt_q + Width'(1);
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and datapath registers; reset returns everything to a quiet idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            max_q   <= '0;
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign tick_o = (state_q == StRun) && ena_i && at_term;
    assign busy_o = (state_q == StRun);
    assign done_o = (state_q == StDone);
    assign err_o  = err_q;

endmodule

// File: tb/tb_iter_counter.sv
// Testbench for iter_counter (Width = 8). Each scenario task pushes the
// expected per-cycle outputs to a scoreboard queue as it drives stimulus and
// pops/compares them once the DUT outputs have settled mid-cycle.

module tb_iter_counter;

    localparam int W = 8;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         clr_i;
    logic         start_i;
    logic         ena_i;
    logic         mode_i;
    logic         dir_i;
    logic [W-1:0] max_i;
    logic [W-1:0] cnt_o;
    logic         tick_o;
    logic         busy_o;
    logic         done_o;
    logic         err_o;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         tick;
        logic         busy;
        logic         done;
        logic         err;
    } exp_t;

    exp_t         sb[$];
    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] held_cnt;

    iter_counter #(.Width(W)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr_i),
        .start_i (start_i),
        .ena_i   (ena_i),
        .mode_i  (mode_i),
        .dir_i   (dir_i),
        .max_i   (max_i),
        .cnt_o   (cnt_o),
        .tick_o  (tick_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk_i = ~clk_i;

    // Safety net so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of inputs on the falling edge, away from the active edge.
    task automatic applyStimulus(input logic start, input logic ena, input logic mode,
                                 input logic dir, input logic clr, input logic [W-1:0] max);
        @(negedge clk_i);
        start_i = start;
        ena_i   = ena;
        mode_i  = mode;
        dir_i   = dir;
        clr_i   = clr;
        max_i   = max;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_ni = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        sb.push_back('{cnt: 8'd0, tick: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0});
        #1;
        e = sb.pop_front();
        checks++;
        if ({cnt_o, tick_o, busy_o, done_o, err_o} !== {e.cnt, e.tick, e.busy, e.done, e.err}) begin
            failures++;
            $display("[TB] FAIL reset_idle: got cnt=%0d tick=%b busy=%b done=%b err=%b, want cnt=%0d tick=%b busy=%b done=%b err=%b",
                     cnt_o, tick_o, busy_o, done_o, err_o, e.cnt, e.tick, e.busy, e.done, e.err);
        end
        // A start while reset is held must not take effect.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5);
        sb.push_back('{cnt: 8'd0, tick: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0});
        #1;
        e = sb.pop_front();
        checks++;
        if ({cnt_o, tick_o, busy_o, done_o, err_o} !== {e.cnt, e.tick, e.busy, e.done, e.err}) begin
            failures++;
            $display("[TB] FAIL reset_hold_start: got cnt=%0d tick=%b busy=%b done=%b err=%b, want cnt=%0d tick=%b busy=%b done=%b err=%b",
                     cnt_o, tick_o, busy_o, done_o, err_o, e.cnt, e.tick, e.busy, e.done, e.err);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        rst_ni   = 1'b1;
        held_cnt = 8'd0;
    endtask

    // One-shot run of length n in direction d with ena held high; max_i is
    // scrambled after the start cycle to show it is latched.
    task automatic test_oneshot(input int n, input logic d, input string tag);
        exp_t         e;
        logic [W-1:0] term;
        term = d ? 8'd0 : W'(n - 1);
        for (int i = 0; i <= n + 2; i++) begin
            applyStimulus(i == 0, 1'b1, 1'b1, d, 1'b0,
                          (i == 0) ? W'(n) : W'($urandom_range(0, 255)));
            if (i == 0)
                e = '{cnt: held_cnt, tick: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0};
            else if (i <= n)
                e = '{cnt: d ? W'(n - i) : W'(i - 1), tick: (i == n), busy: 1'b1, done: 1'b0, err: 1'b0};
            else if (i == n + 1)
                e = '{cnt: term, tick: 1'b0, busy: 1'b0, done: 1'b1, err: 1'b0};
            else
                e = '{cnt: term, tick: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0};
            sb.push_back(e);
            #1;
            e = sb.pop_front();
            checks++;
            if ({cnt_o, tick_o, busy_o, done_o, err_o} !== {e.cnt, e.tick, e.busy, e.done, e.err}) begin
                failures++;
                $display("[TB] FAIL %s cyc%0d: got cnt=%0d tick=%b busy=%b done=%b err=%b, want cnt=%0d tick=%b busy=%b done=%b err=%b",
                         tag, i, cnt_o, tick_o, busy_o, done_o, err_o, e.cnt, e.tick, e.busy, e.done, e.err);
            end
        end
        held_cnt = term;
    endtask

    // Wrap mode, length 3, up: ten enabled cycles, clear in the tenth.
    task automatic test_wrap();
        exp_t e;
        for (int i = 0; i <= 12; i++) begin
            applyStimulus(i == 0, 1'b1, 1'b0, 1'b0, i == 10, 8'd3);
            if (i == 0)
                e = '{cnt: held_cnt, tick: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0};
            else if (i <= 10)
                e = '{cnt: W'((i - 1) % 3), tick: ((i - 1) % 3 == 2), busy: 1'b1, done: 1'b0, err: 1'b0};
            else
                e = '{cnt: 8'd0, tick: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0};
            sb.push_back(e);
            #1;
            e = sb.pop_front();
            checks++;
            if ({cnt_o, tick_o, busy_o, done_o, err_o} !== {e.cnt, e.tick, e.busy, e.done, e.err}) begin
                failures++;
                $display("[TB] FAIL wrap cyc%0d: got cnt=%0d tick=%b busy=%b done=%b err=%b, want cnt=%0d tick=%b busy=%b done=%b err=%b",
                         i, cnt_o, tick_o, busy_o, done_o, err_o, e.cnt, e.tick, e.busy, e.done, e.err);
            end
        end
        held_cnt = 8'd0;
    endtask

    // One-shot length 4 with ena toggling; stray starts in RUN and DONE.
    task automatic test_ena_toggle();
        exp_t e;
        logic ena;
        for (int i = 0; i <= 9; i++) begin
            ena = (i == 0) ? 1'b1 : ((i % 2) == 1);
            applyStimulus((i == 0) || (i == 4) || (i == 8), ena, 1'b1, 1'b0, 1'b0,
                          (i == 0) ? 8'd4 : W'($urandom_range(1, 255)));
            if (i == 0)
                e = '{cnt: held_cnt, tick: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0};
            else if (i <= 7)
                e = '{cnt: W'(i / 2), tick: (i == 7), busy: 1'b1, done: 1'b0, err: 1'b0};
            else if (i == 8)
                e = '{cnt: 8'd3, tick: 1'b0, busy: 1'b0, done: 1'b1, err: 1'b0};
            else
                e = '{cnt: 8'd3, tick: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0};
            sb.push_back(e);
            #1;
            e = sb.pop_front();
            checks++;
            if ({cnt_o, tick_o, busy_o, done_o, err_o} !== {e.cnt, e.tick, e.busy, e.done, e.err}) begin
                failures++;
                $display("[TB] FAIL ena_toggle cyc%0d: got cnt=%0d tick=%b busy=%b done=%b err=%b, want cnt=%0d tick=%b busy=%b done=%b err=%b",
                         i, cnt_o, tick_o, busy_o, done_o, err_o, e.cnt, e.tick, e.busy, e.done, e.err);
            end
        end
        held_cnt = 8'd3;
    endtask

    // Start with max_i == 0 is rejected with a one-cycle err_o pulse.
    task automatic test_err();
        exp_t e;
        for (int i = 0; i <= 2; i++) begin
            applyStimulus(i == 0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
            if (i == 1)
                e = '{cnt: held_cnt, tick: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b1};
            else
                e = '{cnt: held_cnt, tick: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0};
            sb.push_back(e);
            #1;
            e = sb.pop_front();
            checks++;
            if ({cnt_o, tick_o, busy_o, done_o, err_o} !== {e.cnt, e.tick, e.busy, e.done, e.err}) begin
                failures++;
                $display("[TB] FAIL err_zero_len cyc%0d: got cnt=%0d tick=%b busy=%b done=%b err=%b, want cnt=%0d tick=%b busy=%b done=%b err=%b",
                         i, cnt_o, tick_o, busy_o, done_o, err_o, e.cnt, e.tick, e.busy, e.done, e.err);
            end
        end
    endtask

    // Asynchronous reset in the middle of a run, between clock edges.
    task automatic test_async_reset();
        exp_t e;
        for (int i = 0; i <= 4; i++) begin
            applyStimulus(i == 0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5);
            if (i == 0)
                e = '{cnt: held_cnt, tick: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0};
            else
                e = '{cnt: W'(i - 1), tick: 1'b0, busy: 1'b1, done: 1'b0, err: 1'b0};
            sb.push_back(e);
            #1;
            e = sb.pop_front();
            checks++;
            if ({cnt_o, tick_o, busy_o, done_o, err_o} !== {e.cnt, e.tick, e.busy, e.done, e.err}) begin
                failures++;
                $display("[TB] FAIL async_reset_run cyc%0d: got cnt=%0d tick=%b busy=%b done=%b err=%b, want cnt=%0d tick=%b busy=%b done=%b err=%b",
                         i, cnt_o, tick_o, busy_o, done_o, err_o, e.cnt, e.tick, e.busy, e.done, e.err);
            end
        end
        #2;
        rst_ni = 1'b0;
        sb.push_back('{cnt: 8'd0, tick: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0});
        #1;
        e = sb.pop_front();
        checks++;
        if ({cnt_o, tick_o, busy_o, done_o, err_o} !== {e.cnt, e.tick, e.busy, e.done, e.err}) begin
            failures++;
            $display("[TB] FAIL async_reset_now: got cnt=%0d tick=%b busy=%b done=%b err=%b, want cnt=%0d tick=%b busy=%b done=%b err=%b",
                     cnt_o, tick_o, busy_o, done_o, err_o, e.cnt, e.tick, e.busy, e.done, e.err);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
        rst_ni = 1'b1;
        sb.push_back('{cnt: 8'd0, tick: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0});
        #1;
        e = sb.pop_front();
        checks++;
        if ({cnt_o, tick_o, busy_o, done_o, err_o} !== {e.cnt, e.tick, e.busy, e.done, e.err}) begin
            failures++;
            $display("[TB] FAIL async_reset_after: got cnt=%0d tick=%b busy=%b done=%b err=%b, want cnt=%0d tick=%b busy=%b done=%b err=%b",
                     cnt_o, tick_o, busy_o, done_o, err_o, e.cnt, e.tick, e.busy, e.done, e.err);
        end
        held_cnt = 8'd0;
    endtask

    // Clear coincident with the one-shot terminal tick, then with a start.
    task automatic test_clr();
        exp_t e;
        for (int i = 0; i <= 7; i++) begin
            applyStimulus((i == 0) || (i == 5), 1'b1, 1'b1, 1'b0, (i == 2) || (i == 5), (i == 5) ? 8'd5 : 8'd2);
            if (i == 0)
                e = '{cnt: held_cnt, tick: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0};
            else if (i == 1)
                e = '{cnt: 8'd0, tick: 1'b0, busy: 1'b1, done: 1'b0, err: 1'b0};
            else if (i == 2)
                e = '{cnt: 8'd1, tick: 1'b1, busy: 1'b1, done: 1'b0, err: 1'b0};
            else
                e = '{cnt: 8'd0, tick: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0};
            sb.push_back(e);
            #1;
            e = sb.pop_front();
            checks++;
            if ({cnt_o, tick_o, busy_o, done_o, err_o} !== {e.cnt, e.tick, e.busy, e.done, e.err}) begin
                failures++;
                $display("[TB] FAIL clr cyc%0d: got cnt=%0d tick=%b busy=%b done=%b err=%b, want cnt=%0d tick=%b busy=%b done=%b err=%b",
                         i, cnt_o, tick_o, busy_o, done_o, err_o, e.cnt, e.tick, e.busy, e.done, e.err);
            end
        end
        held_cnt = 8'd0;
    endtask

    initial begin
        rst_ni  = 1'b0;
        clr_i   = 1'b0;
        start_i = 1'b0;
        ena_i   = 1'b0;
        mode_i  = 1'b0;
        dir_i   = 1'b0;
        max_i   = '0;
        test_reset();
        test_oneshot(5, 1'b0, "oneshot_up5");
        test_oneshot(5, 1'b1, "oneshot_down5");
        test_wrap();
        test_ena_toggle();
        test_err();
        test_oneshot(1, 1'b0, "oneshot_len1");
        test_async_reset();
        test_clr();
        test_oneshot(255, 1'b0, "oneshot_up255");
        test_oneshot(2, 1'b1, "back_to_back_down2");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iter_counter.md
Name: iter_counter

Overview:
- Parametrised, mode-programmable successor to the basic enable/max counter; drives CORDIC iteration sequencing.
- Adds a start/busy/done handshake, up/down direction, and one-shot vs wrap modes.
- Latches the terminal count at start, provides a synchronous clear, and flags an illegal length.
- Sits between the CORDIC control FSM and the micro-rotation datapath; cnt_o indexes the iteration and atan ROM.

Parameters:
- Width, 16, bit width of max_i and cnt_o; legal range 2..32.

Ports:
- clk_i  input  1  rising-edge clock
- rst_ni  input  1  asynchronous reset, active low; one clock domain only
- clr_i  input  1  synchronous clear; highest priority after reset
- start_i  input  1  start request; sampled in IDLE only
- ena_i  input  1  count enable; freezes count and state when low in RUN
- mode_i  input  1  0 = wrap (free-run), 1 = one-shot; latched at accepted start
- dir_i  input  1  0 = up, 1 = down; latched at accepted start
- max_i  input  Width  sequence length N; latched at accepted start
- cnt_o  output  Width  current count (registered)
- tick_o  output  1  terminal-count strobe (combinational from registers and ena_i)
- busy_o  output  1  high in RUN
- done_o  output  1  one-cycle pulse, one-shot completion
- err_o  output  1  one-cycle pulse, start rejected (max_i == 0)

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE, cnt_o = 0, latched max/mode/dir = 0, busy_o = 0, done_o = 0, err_o = 0. tick_o therefore reads 0.
- States: IDLE, RUN, DONE. busy_o = (state == RUN). done_o = (state == DONE). err_o is a registered flag.
- IDLE, start_i = 1, max_i != 0:
  - Latch max_q, mode_q and dir_q.
  - Load cnt_o with the start value: 0 for up, max_i-1 for down.
  - Go to RUN. First count value is visible the cycle after start_i.
- IDLE, start_i = 1, max_i == 0: stay IDLE, cnt_o unchanged, err_o = 1 for exactly the next cycle.
- start_i is ignored in RUN and DONE. It is not queued.
- Terminal value: max_q-1 for up, 0 for down.
- at_term = (cnt_o == terminal value).
- tick_o = (state == RUN) & ena_i & at_term.
- RUN, ena_i = 1, not at_term: cnt_o += 1 (up) or -= 1 (down). Arithmetic is modulo 2^Width, but a legal sequence never wraps.
- RUN, ena_i = 1, at_term:
  - Wrap mode: reload the start value and stay in RUN.
  - One-shot mode: cnt_o holds the terminal value; go to DONE.
- RUN, ena_i = 0: all state frozen; tick_o = 0.
- DONE lasts exactly one cycle (done_o = 1), then IDLE. cnt_o holds its value through DONE and IDLE until the next accepted start.
- max_q = 1: the start value equals the terminal value, so tick_o asserts on every enabled RUN cycle. In one-shot, done_o follows one enabled cycle after entering RUN.
- max_q = 2^Width-1 is legal; no overflow occurs.
- clr_i = 1 in any state: next cycle state IDLE, cnt_o = 0, done_o = 0, err_o = 0.
  - clr_i overrides a coincident start_i and a coincident terminal event.
  - No done_o pulse is produced for an aborted run.
  - tick_o is still combinationally high in the clr_i cycle if its conditions hold.
- Wrap mode runs until clr_i. done_o never asserts in wrap mode.
- max_i changes during RUN have no effect.
- Asynchronous reset mid-run aborts immediately; no pulses are emitted.

Test Plan:
- Width = 8; start, mode = 1, dir = 0, max = 5, ena held high:
  - cnt_o = 0,1,2,3,4 in cycles 1..5 after start.
  - tick_o high only in the cycle cnt_o = 4.
  - done_o pulses in cycle 6; busy_o high in cycles 1..5.
  - cnt_o stays at 4 afterwards.
- Same with dir = 1: cnt_o = 4,3,2,1,0; tick_o at 0; done_o one cycle later; busy_o drops with done_o rising.
- Wrap mode, max = 3, up, 10 enabled cycles:
  - cnt_o = 0,1,2,0,1,2,0,1,2,0.
  - tick_o high in every cycle where cnt_o = 2.
  - done_o never asserts.
  - Then clr_i: cnt_o = 0, IDLE, busy_o = 0.
- One-shot, max = 4, ena toggled 1,0,1,0,...:
  - cnt_o advances only on ena_i = 1 cycles.
  - tick_o is never high while ena_i = 0.
  - done_o arrives after 4 enabled cycles.
  - A start_i pulse mid-run is ignored.
- start with max = 0: err_o pulses one cycle, busy_o stays 0, cnt_o unchanged. A subsequent start with max = 1 gives tick_o on the first RUN cycle and done_o the next cycle.
- rst_ni low mid-run at cnt_o = 3: all outputs go to 0 asynchronously before the next edge. clr_i coincident with the one-shot terminal tick gives IDLE and no done_o.
